// File: rtl/fetch_unit_if.sv
// fetch_unit_if: memory bus, control inputs and IF/ID outputs of the fetch stage
interface fetch_unit_if;
    logic        stall;
    logic        branchTaken;
    logic [63:0] branchTarget;
    logic [63:0] instructionAddress;
    logic [31:0] instruction;
    logic [63:0] ifPc;
    logic [31:0] ifInstruction;
    logic        ifValid;
    logic [63:0] fetchCount;
    modport master (
        input  stall, branchTaken, branchTarget, instruction,
        output instructionAddress, ifPc, ifInstruction, ifValid, fetchCount
    );
    modport slave (
        output stall, branchTaken, branchTarget, instruction,
        input  instructionAddress, ifPc, ifInstruction, ifValid, fetchCount
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC generation, outstanding-request tracking and IF/ID register for a registered instruction memory
module fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter logic [63:0] PC_STEP  = 64'd4
) (
    input logic        clk,
    input logic        rst_n,
    fetch_unit_if.master bus
);
    logic [63:0] pc;
    logic [63:0] req_pc;
    logic        req_valid;
    logic [63:0] target;

    assign target = {bus.branchTarget[63:2], 2'b00};
    // On stall the memory re-reads the outstanding address so its output stays put
    assign bus.instructionAddress = bus.branchTaken ? target : bus.stall ? req_pc : pc;

    // Redirect beats stall; stall freezes everything; otherwise advance one slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc                <= RESET_PC;
            req_pc            <= RESET_PC;
            req_valid         <= 1'b0;
            bus.ifPc          <= '0;
            bus.ifInstruction <= '0;
            bus.ifValid       <= 1'b0;
            bus.fetchCount    <= '0;
        end else if (bus.branchTaken) begin
            req_pc      <= target;
            req_valid   <= 1'b1;
            pc          <= target + PC_STEP;
            bus.ifValid <= 1'b0;
        end else if (!bus.stall) begin
            bus.ifPc          <= req_pc;
            bus.ifInstruction <= bus.instruction;
            bus.ifValid       <= req_valid;
            bus.fetchCount    <= bus.fetchCount + {63'd0, req_valid};
            req_pc            <= pc;
            req_valid         <= 1'b1;
            pc                <= pc + PC_STEP;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and random checks of fetch_unit against a queue-based fetch model
module tb_fetch_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    fetch_unit_if bus ();
    fetch_unit_if bus2 ();

    fetch_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    fetch_unit #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFF8)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [63:0] a);
        case (a)
            64'h0:   return 32'h00500093;
            64'h4:   return 32'h00A00113;
            64'h8:   return 32'h002081B3;
            default: return a[31:0] ^ a[63:32] ^ 32'h9E3779B9;
        endcase
    endfunction

    // Registered-read instruction memory
    always @(posedge clk) begin
        bus.instruction  <= mem(bus.instructionAddress);
        bus2.instruction <= mem(bus2.instructionAddress);
    end

    // Model: q holds the request the memory is currently answering (empty right after reset)
    logic [63:0] m_q[$];
    logic [63:0] m_next;
    logic [63:0] m_cnt;
    logic        e_v;
    logic [63:0] e_pc;
    logic [31:0] e_in;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] m_addr(input logic s, input logic b, input logic [63:0] t);
        if (b) return {t[63:2], 2'b00};
        if (s) return (m_q.size() != 0) ? m_q[0] : 64'h0;
        return m_next;
    endfunction

    task automatic m_reset();
        m_q.delete();
        m_next = 64'h0;
        m_cnt  = 64'h0;
        e_v    = 1'b0;
        e_pc   = 64'h0;
        e_in   = 32'h0;
    endtask

    task automatic m_edge(input logic s, input logic b, input logic [63:0] t);
        logic [63:0] ta;
        ta = {t[63:2], 2'b00};
        if (b) begin
            e_v = 1'b0;
            m_q.delete();
            m_q.push_back(ta);
            m_next = ta + 64'd4;
        end else if (!s) begin
            if (m_q.size() != 0) begin
                e_v  = 1'b1;
                e_pc = m_q.pop_front();
                e_in = mem(e_pc);
                m_cnt = m_cnt + 64'd1;
            end else begin
                e_v = 1'b0;
            end
            m_q.push_back(m_next);
            m_next = m_next + 64'd4;
        end
    endtask

    // One clock: drive at negedge, check address, take the edge, check IF/ID
    task automatic cyc(input logic s, input logic b, input logic [63:0] t);
        bus.stall        = s;
        bus.branchTaken  = b;
        bus.branchTarget = t;
        #1;
        chk("instructionAddress", bus.instructionAddress, m_addr(s, b, t));
        @(posedge clk);
        m_edge(s, b, t);
        #1;
        chk("ifValid", {63'd0, bus.ifValid}, {63'd0, e_v});
        chk("fetchCount", bus.fetchCount, m_cnt);
        if (e_v) begin
            chk("ifPc", bus.ifPc, e_pc);
            chk("ifInstruction", {32'd0, bus.ifInstruction}, {32'd0, e_in});
        end
        @(negedge clk);
    endtask

    // Assert reset between edges and check it takes effect without a clock
    task automatic pulse_reset();
        bus.stall       = 1'b0;
        bus.branchTaken = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        m_reset();
        chk("rst_ifValid", {63'd0, bus.ifValid}, 64'd0);
        chk("rst_fetchCount", bus.fetchCount, 64'd0);
        chk("rst_ifPc", bus.ifPc, 64'd0);
        chk("rst_ifInstruction", {32'd0, bus.ifInstruction}, 64'd0);
        chk("rst_instructionAddress", bus.instructionAddress, 64'd0);
        chk("rst_wrap_instructionAddress", bus2.instructionAddress, 64'hFFFF_FFFF_FFFF_FFF8);
        @(posedge clk);
        bus.stall = 1'b1;
        @(negedge clk);
        chk("rst_stall_instructionAddress", bus.instructionAddress, 64'd0);
        bus.stall = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        bus.stall         = 1'b0;
        bus.branchTaken   = 1'b0;
        bus.branchTarget  = 64'h0;
        bus2.stall        = 1'b0;
        bus2.branchTaken  = 1'b0;
        bus2.branchTarget = 64'h0;
        @(negedge clk);
        pulse_reset();

        // Sequential fetch from reset, plus wrap on the second instance
        cyc(0, 0, 0);
        chk("first_edge_ifValid", {63'd0, bus.ifValid}, 64'd0);
        cyc(0, 0, 0);
        chk("edge2_ifPc", bus.ifPc, 64'h0);
        chk("edge2_ifInstruction", {32'd0, bus.ifInstruction}, 64'h00500093);
        chk("wrap_edge2_ifPc", bus2.ifPc, 64'hFFFF_FFFF_FFFF_FFF8);
        chk("wrap_edge2_ifValid", {63'd0, bus2.ifValid}, 64'd1);
        cyc(0, 0, 0);
        chk("edge3_ifPc", bus.ifPc, 64'h4);
        chk("wrap_edge3_ifPc", bus2.ifPc, 64'hFFFF_FFFF_FFFF_FFFC);
        cyc(0, 0, 0);
        chk("edge4_ifPc", bus.ifPc, 64'h8);
        chk("edge4_fetchCount", bus.fetchCount, 64'd3);
        chk("wrap_edge4_ifPc", bus2.ifPc, 64'h0);
        chk("wrap_edge4_ifValid", {63'd0, bus2.ifValid}, 64'd1);

        // Stall for three cycles while ifPc=4
        pulse_reset();
        repeat (3) cyc(0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 0);
            chk("stall_ifPc", bus.ifPc, 64'h4);
            chk("stall_ifInstruction", {32'd0, bus.ifInstruction}, 64'h00A00113);
        end
        cyc(0, 0, 0);
        chk("unstall_ifPc", bus.ifPc, 64'h8);
        chk("unstall_ifInstruction", {32'd0, bus.ifInstruction}, 64'h002081B3);

        // Redirect to 0x40 while ifPc=4
        pulse_reset();
        repeat (3) cyc(0, 0, 0);
        cyc(0, 1, 64'h40);
        chk("flush_ifValid", {63'd0, bus.ifValid}, 64'd0);
        chk("flush_fetchCount", bus.fetchCount, 64'd2);
        cyc(0, 0, 0);
        chk("target_ifPc", bus.ifPc, 64'h40);
        chk("target_fetchCount", bus.fetchCount, 64'd3);

        // Redirect together with stall, misaligned target
        cyc(1, 1, 64'h103);
        chk("redirect_stall_ifValid", {63'd0, bus.ifValid}, 64'd0);
        cyc(1, 0, 0);
        cyc(1, 1, 64'h200);
        cyc(0, 1, 64'h301);
        chk("double_redirect_ifValid", {63'd0, bus.ifValid}, 64'd0);
        cyc(0, 0, 0);
        chk("double_redirect_ifPc", bus.ifPc, 64'h300);

        // Random traffic with occasional asynchronous resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 149) == 0) pulse_reset();
            else cyc($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, {$urandom, $urandom});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage placed directly upstream of instruction_memory.
- Holds the program counter and drives instructionAddress into the memory.
- Tracks which address is outstanding, since the memory registers its read: instruction is valid one edge after the address is sampled.
- Registers {pc, instruction, valid} into the IF/ID boundary for decode, with stall and branch-redirect/flush handling.

Parameters:
- RESET_PC, 64'h0, first fetch address after reset.
- PC_STEP, 4, byte increment per sequential fetch.

Ports:
- clk  input  1  rising-edge clock, shared with instruction_memory.
- rst_n  input  1  asynchronous, active-low reset.
- stall  input  1  decode back-pressure; hold the fetch pipeline.
- branchTaken  input  1  redirect request from execute.
- branchTarget  input  64  redirect address; bits [1:0] are ignored (forced 0).
- instructionAddress  output  64  address to instruction_memory (combinational mux).
- instruction  input  32  read data from instruction_memory, for the address sampled at the previous edge.
- ifPc  output  64  IF/ID registered PC.
- ifInstruction  output  32  IF/ID registered instruction.
- ifValid  output  1  IF/ID entry valid.
- fetchCount  output  64  number of valid entries accepted into IF/ID.

Behaviour:
- Internal registers:
  - pc: next address to issue.
  - reqPc / reqValid: address sampled by memory at the last edge; its data is on instruction now.
  - IF/ID registers and fetchCount.
- Reset (rst_n low, asynchronous):
  - pc = reqPc = RESET_PC, reqValid = 0.
  - ifPc = 0, ifInstruction = 0, ifValid = 0, fetchCount = 0.
  - instructionAddress therefore reads RESET_PC while in reset.
- instructionAddress mux, in priority order:
  - branchTaken: {branchTarget[63:2], 2'b00}.
  - stall: reqPc. The memory re-reads the outstanding address, so its output is preserved.
  - otherwise: pc.
- Normal edge (no branch, no stall):
  - IF/ID <= {reqPc, instruction, reqValid}.
  - reqPc <= pc, reqValid <= 1.
  - pc <= pc + PC_STEP.
  - fetchCount += 1 when reqValid.
- Stall edge (no branch): pc, reqPc, reqValid, IF/ID and fetchCount all hold.
- Redirect edge (branchTaken, overrides stall), with aligned target T:
  - reqPc <= T, reqValid <= 1, pc <= T + PC_STEP.
  - ifValid <= 0 (flush the wrong-path instruction); ifPc and ifInstruction may update but are don't-care.
  - fetchCount unchanged.
- Latency:
  - Address issued at edge k appears on ifPc/ifInstruction/ifValid after edge k+1, absent stall or redirect.
  - After reset release, the first valid IF/ID entry (RESET_PC) appears after the 2nd rising edge.
  - After a redirect edge, the target's entry appears valid after the next non-stalled edge.
- Arithmetic: pc + PC_STEP wraps modulo 2^64 (64'hFFFF_FFFF_FFFF_FFFC -> 0), with no flag. fetchCount also wraps.
- Stall during reset is ignored.
- Reset asserted mid-operation immediately restores all reset values, including cancelling any outstanding request.
- branchTaken and stall in the same cycle: the redirect wins. When stall persists on the next cycle, the target is held outstanding.
- Consecutive redirect cycles: the last target wins; ifValid stays 0.

Test Plan:
- Reset release, memory holding 32'h00500093 @0, 32'h00A00113 @4, 32'h002081B3 @8, no stall:
  - ifValid rises after edge 2 with ifPc=0, ifInstruction=32'h00500093.
  - Then ifPc=4 and ifPc=8 on successive edges.
  - fetchCount=3 after edge 4.
- stall high for 3 cycles while ifPc=4:
  - instructionAddress=8 throughout.
  - IF/ID holds {4, 32'h00A00113, 1}.
  - After release, the next edge gives ifPc=8, ifInstruction=32'h002081B3 (nothing lost or duplicated).
- branchTaken with branchTarget=64'h40 while ifPc=4:
  - instructionAddress=64'h40 that cycle.
  - Next edge: ifValid=0.
  - Following edge: ifPc=64'h40, ifValid=1.
  - fetchCount is not incremented by the flushed slot.
- branchTaken with stall together, target 64'h103 (misaligned):
  - instructionAddress=64'h100.
  - Redirect taken despite stall; ifValid=0.
  - Keeping stall high the next cycle holds instructionAddress=64'h100.
- RESET_PC=64'hFFFF_FFFF_FFFF_FFF8:
  - Valid entries carry ifPc FFF8, FFFC, then 0: pc wraps.
- rst_n pulsed low asynchronously mid-stream (between edges):
  - ifValid=0, fetchCount=0, instructionAddress=RESET_PC immediately, without waiting for a clock edge.
  - Resumes per the first scenario after release.
